// File: rtl/fifo_pkg.sv
// Shared types and default widths for the async FIFO read-side controller.
package fifo_pkg;

  localparam int FIFO_DATA_W = 8;
  localparam int FIFO_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } rd_state_t;

endpackage

// File: rtl/afifo_rd_skid.sv
// Two-entry ordered output buffer: head is presented, tail queues behind it.
module afifo_rd_skid import fifo_pkg::*; #(
  parameter int DATA_W = FIFO_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [1:0]        o_occ,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W-1:0] r_head;
  logic [DATA_W-1:0] r_tail;
  logic [1:0]        r_occ;
  logic              w_pop;

  assign w_pop = i_pop && (r_occ != 2'd0);

  // Buffer storage and occupancy; push+pop together keeps occupancy constant.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_head <= {DATA_W{1'b0}};
      r_tail <= {DATA_W{1'b0}};
      r_occ  <= 2'd0;
    end else begin
      case ({i_push, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) begin
            r_head <= i_data;
            r_occ  <= 2'd1;
          end else if (r_occ == 2'd1) begin
            r_tail <= i_data;
            r_occ  <= 2'd2;
          end else begin
            r_occ  <= r_occ;
          end
        end
        2'b01: begin
          if (r_occ == 2'd2) begin
            r_head <= r_tail;
            r_occ  <= 2'd1;
          end else begin
            r_occ  <= 2'd0;
          end
        end
        2'b11: begin
          if (r_occ == 2'd2) begin
            r_head <= r_tail;
            r_tail <= i_data;
          end else begin
            r_head <= i_data;
          end
        end
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_occ   = r_occ;
  assign o_valid = (r_occ != 2'd0);
  assign o_data  = r_head;

endmodule

// File: rtl/afifo_rd_ctrl.sv
// Read-side controller for an async FIFO: pops with 1-cycle latency into a 2-entry skid.
// Optional even-parity checking on data_out is compiled in with macro AFIFO_RD_PARITY_EN.
module afifo_rd_ctrl import fifo_pkg::*; #(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int CNT_W  = FIFO_CNT_W
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic              enable,
  input  logic              flush,
  input  logic              empty,
`ifdef AFIFO_RD_PARITY_EN
  input  logic [DATA_W:0]   data_out,
  output logic              parity_err,
`else
  input  logic [DATA_W-1:0] data_out,
`endif
  output logic              pop,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [CNT_W-1:0]  rd_count,
  output logic              busy
);

  rd_state_t         r_state;
  rd_state_t         w_state_nxt;
  logic              r_inflight;
  logic [CNT_W-1:0]  r_rd_count;
  logic [1:0]        w_occ;
  logic [2:0]        w_level;
  logic              w_fire;
  logic              w_push;
  logic              w_pop;
  logic [DATA_W-1:0] w_payload;

  // A flush cycle neither counts a beat nor captures the landing word.
  assign w_fire  = m_valid && m_ready && !flush;
  assign w_push  = r_inflight && !flush;
  assign w_level = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_fire};
  assign w_pop   = (r_state == ST_RUN) && enable && !empty && !flush && !rd_rst
                   && (w_level < 3'd2);

  // Next-state selection; flush overrides every other condition.
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_FLUSH;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (enable) w_state_nxt = ST_RUN;
          else        w_state_nxt = ST_IDLE;
        end
        ST_RUN: begin
          if (!enable && !r_inflight) w_state_nxt = ST_IDLE;
          else                        w_state_nxt = ST_RUN;
        end
        ST_FLUSH: w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State, in-flight tracking and the wrapping delivered-beat counter.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_state    <= ST_IDLE;
      r_inflight <= 1'b0;
      r_rd_count <= {CNT_W{1'b0}};
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_pop;
      if (w_fire) r_rd_count <= r_rd_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

`ifdef AFIFO_RD_PARITY_EN
  logic r_parity_err;

  function automatic logic f_parity_bad(input logic [DATA_W:0] word);
    return ^word;
  endfunction

  // Sticky flag: any captured word with odd overall parity latches it until reset.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_parity_err <= 1'b0;
    end else if (w_push && f_parity_bad(data_out)) begin
      r_parity_err <= 1'b1;
    end
  end

  assign parity_err = r_parity_err;
  assign w_payload  = data_out[DATA_W-1:0];
`else
  assign w_payload  = data_out;
`endif

  afifo_rd_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk     (rd_clk),
    .rst     (rd_rst),
    .i_clr   (flush),
    .i_push  (w_push),
    .i_data  (w_payload),
    .i_pop   (w_fire),
    .o_occ   (w_occ),
    .o_valid (m_valid),
    .o_data  (m_data)
  );

  assign pop      = w_pop;
  assign rd_count = r_rd_count;
  assign busy     = (r_state != ST_IDLE) || (w_occ != 2'd0) || r_inflight;

endmodule

// File: doc/afifo_rd_ctrl.md
AFIFO_RD_CTRL -- requirements
Module: afifo_rd_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload width excluding the optional parity bit.
REQ-002 SHALL have parameter CNT_W, default 16, width of the delivered-beat counter.
REQ-003 SHALL use a single clock, rd_clk; reset rd_rst is synchronous and active-high.
REQ-004 SHALL have port rd_clk  input  1  read-domain clock.
REQ-005 SHALL have port rd_rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port enable  input  1  permits new FIFO pops when high.
REQ-007 SHALL have port flush  input  1  one-cycle pulse; discards buffered and in-flight data.
REQ-008 SHALL have port empty  input  1  FIFO read-side empty flag.
REQ-009 SHALL have port data_out  input  DATA_W(+1 with parity)  FIFO read data, valid one cycle after pop.
REQ-010 SHALL have port pop  output  1  FIFO read strobe.
REQ-011 SHALL have port m_valid  output  1  downstream beat valid.
REQ-012 SHALL have port m_ready  input  1  downstream accept.
REQ-013 SHALL have port m_data  output  DATA_W  downstream payload.
REQ-014 SHALL have port rd_count  output  CNT_W  count of accepted downstream beats.
REQ-015 SHALL have port busy  output  1  high when state is not IDLE or data is held or in flight.

Function
REQ-016 SHALL run an FSM with states IDLE, RUN and FLUSH; it enters RUN from IDLE when enable=1, returns to IDLE from RUN when enable=0 and nothing is in flight, and enters FLUSH from any state on flush=1.
REQ-017 SHALL assert pop only in RUN, and only when empty=0 and (occupancy + inflight - (m_valid&&m_ready)) < 2.
REQ-018 SHALL treat FIFO read latency as exactly 1 cycle and capture data_out into a 2-entry output buffer on the cycle after pop.
REQ-019 SHALL present buffered entries in FIFO order; m_valid=1 whenever occupancy>0, and m_data/m_valid hold stable while m_valid=1 and m_ready=0.
REQ-020 SHALL sustain one beat per cycle when empty=0 and m_ready=1 continuously.
REQ-021 SHALL never assert pop while empty=1 (no underflow) and never overrun the buffer (occupancy<=2).
REQ-022 SHALL give a simultaneous arrival and departure with full buffer a net occupancy change of zero, with no loss.
REQ-023 SHALL increment rd_count on each m_valid&&m_ready, wrapping from 2^CNT_W-1 to 0.
REQ-024 SHALL in FLUSH hold pop=0 and m_valid=0, drop the landing in-flight word, clear the buffer, then go to IDLE the next cycle; rd_count is unchanged.
REQ-025 SHALL give flush priority over enable, pop and m_ready when they occur in the same cycle; the beat is not counted.

Reset
REQ-026 SHALL on rd_rst=1 set state=IDLE, pop=0, m_valid=0, m_data=0, rd_count=0, busy=0, occupancy=0, inflight=0, and parity_err=0 if present.
REQ-027 SHALL on reset mid-operation discard in-flight and buffered data; the FIFO read side shares rd_rst.

Configuration
REQ-028 SHALL compile in the parity feature when macro AFIFO_RD_PARITY_EN is defined: data_out is DATA_W+1 bits, MSB is even parity over the payload, and a sticky output parity_err (1 bit) sets on any captured word with bad parity and clears only on rd_rst.
REQ-029 SHALL, without AFIFO_RD_PARITY_EN, have data_out of DATA_W bits, no parity_err port, and no parity logic.

Structure
REQ-030 SHALL place the state enum typedef (rd_state_t) and the default DATA_W/CNT_W constants in fifo_pkg.
REQ-031 SHALL implement the 2-entry ordered output buffer as sub-module afifo_rd_skid (push/pop/occupancy, DATA_W wide).

Verification
REQ-032 SHALL cover streaming: FIFO holds 0x11..0x18, enable=1, m_ready=1 -> 8 beats 0x11..0x18 on consecutive cycles, rd_count=8.
REQ-033 SHALL cover backpressure: m_ready=0 for 10 cycles with FIFO non-empty -> at most 2 pops, m_data stable, no loss when m_ready returns.
REQ-034 SHALL cover empty boundary: FIFO holds 1 word -> exactly one pop, no pop while empty=1, m_valid drops after the beat.
REQ-035 SHALL cover flush: flush with 2 buffered and 1 in flight -> m_valid=0 next cycle, busy=0 within 2 cycles, rd_count unchanged.
REQ-036 SHALL cover counter wrap: CNT_W=4, deliver 17 beats -> rd_count=1.
REQ-037 SHALL cover parity (with AFIFO_RD_PARITY_EN): inject word 0x03 with parity bit 1 -> parity_err=1 and it stays set until rd_rst.
